// File: rtl/frame_buffer_reader_pkg.sv
// Shared definitions for the camera frame path: bus widths common with the
// capture block, the default frame size, and the readback state encoding.
package frame_buffer_reader_pkg;

    localparam int ADDR_WIDTH_DEF  = 15;
    localparam int DATA_WIDTH_DEF  = 8;
    localparam int FRAME_BYTES_DEF = 19200;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/frame_buffer_reader_pixel_skid_fifo.sv
// Two-entry first-word-fall-through buffer for {first, last, data} words.
// A word pushed into an empty buffer is presented at the head in the same cycle.
module pixel_skid_fifo #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_reg [2];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic             store;
    logic             take;

    assign empty = (count_reg == 2'd0);
    assign full  = (count_reg == 2'd2);
    assign valid = !empty || push;
    assign dout  = empty ? din : mem_reg[rd_ptr_reg];

    // A word that arrives into an empty buffer and is popped at once never gets stored.
    assign take  = pop && !empty;
    assign store = push && !(pop && empty);

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < 2; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (store) begin
                mem_reg[wr_ptr_reg] <= din;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (take) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, store} - {1'b0, take};
        end
    end

endmodule

// File: rtl/frame_buffer_reader.sv
// Streams one stored camera frame out of the frame RAM read port as a
// valid/ready byte stream, one byte per clock when the consumer keeps up.
module frame_buffer_reader
    import frame_buffer_reader_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int FRAME_BYTES = FRAME_BYTES_DEF
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Start,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic [ADDR_WIDTH-1:0] o_RAM_Adress,
    output logic                  o_RAM_Read_Enable,
    input  logic [DATA_WIDTH-1:0] i_from_RAM,
    output logic [DATA_WIDTH-1:0] o_Data,
    output logic                  o_Valid,
    input  logic                  i_Ready,
    output logic                  o_First,
    output logic                  o_Last
);

    localparam int FIFO_WIDTH = DATA_WIDTH + 2;
    localparam logic [ADDR_WIDTH:0] FRAME_END = (ADDR_WIDTH + 1)'(FRAME_BYTES);
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(FRAME_BYTES - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH:0]   cnt_reg, cnt_next;
    logic [ADDR_WIDTH-1:0] addr_hold_reg, addr_hold_next;
    logic                  inflight_reg;
    logic                  first_pend_reg;
    logic                  last_pend_reg;

    logic                  issue;
    logic                  pop;
    logic                  fifo_valid;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FIFO_WIDTH-1:0] fifo_din;
    logic [FIFO_WIDTH-1:0] fifo_dout;
    logic [2:0]            pending;

    // Flags travel with the outstanding read so they line up with its returning byte.
    assign fifo_din = {first_pend_reg, last_pend_reg, i_from_RAM};

    pixel_skid_fifo #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk   (i_Clk),
        .srst  (i_Rst),
        .push  (inflight_reg),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .valid (fifo_valid),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign pop = fifo_valid && i_Ready;

    // Words owed to the consumer after this edge: in flight plus stored, minus this cycle's pop.
    assign pending = {2'b00, inflight_reg}
                   + {1'b0, fifo_full, (!fifo_empty && !fifo_full)}
                   - {2'b00, pop};

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        addr_hold_next = addr_hold_reg;
        issue          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (i_Start) begin
                    state_next = ST_READ;
                    cnt_next   = '0;
                end
            end
            ST_READ: begin
                if ((cnt_reg < FRAME_END) && (pending < 3'd2)) begin
                    issue          = 1'b1;
                    cnt_next       = cnt_reg + CNT_ONE;
                    addr_hold_next = cnt_reg[ADDR_WIDTH-1:0];
                    if (cnt_reg == LAST_ADDR) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pending == 3'd0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            addr_hold_reg  <= '0;
            inflight_reg   <= 1'b0;
            first_pend_reg <= 1'b0;
            last_pend_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            addr_hold_reg <= addr_hold_next;
            inflight_reg  <= issue;
            if (issue) begin
                first_pend_reg <= (cnt_reg == '0);
                last_pend_reg  <= (cnt_reg == LAST_ADDR);
            end
        end
    end

    assign o_Busy            = (state_reg != ST_IDLE);
    assign o_Done            = (state_reg == ST_DONE);
    assign o_RAM_Read_Enable = issue;
    assign o_RAM_Adress      = issue ? cnt_reg[ADDR_WIDTH-1:0] : addr_hold_reg;
    assign o_Valid           = fifo_valid;
    assign o_Data            = fifo_valid ? fifo_dout[DATA_WIDTH-1:0] : '0;
    assign o_First           = fifo_valid && fifo_dout[DATA_WIDTH+1];
    assign o_Last            = fifo_valid && fifo_dout[DATA_WIDTH];

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Directed bench: an 8-byte frame reader and a 1-byte frame reader, each fed
// by a RAM model returning address+0x10 one cycle after a read strobe.
module tb_frame_buffer_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_drv;
    logic start_drv;
    logic ready_drv;
    logic sel_b;

    logic        start_a, busy_a, done_a, rd_a, valid_a, first_a, last_a;
    logic [14:0] addr_a;
    logic [7:0]  ram_a, data_a;
    logic        start_b, busy_b, done_b, rd_b, valid_b, first_b, last_b;
    logic [14:0] addr_b;
    logic [7:0]  ram_b, data_b;

    assign start_a = start_drv && !sel_b;
    assign start_b = start_drv && sel_b;

    frame_buffer_reader #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .FRAME_BYTES(8)) dut_a (
        .i_Clk (clk), .i_Rst (rst_drv), .i_Start (start_a),
        .o_Busy (busy_a), .o_Done (done_a),
        .o_RAM_Adress (addr_a), .o_RAM_Read_Enable (rd_a), .i_from_RAM (ram_a),
        .o_Data (data_a), .o_Valid (valid_a), .i_Ready (ready_drv),
        .o_First (first_a), .o_Last (last_a)
    );

    frame_buffer_reader #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .FRAME_BYTES(1)) dut_b (
        .i_Clk (clk), .i_Rst (rst_drv), .i_Start (start_b),
        .o_Busy (busy_b), .o_Done (done_b),
        .o_RAM_Adress (addr_b), .o_RAM_Read_Enable (rd_b), .i_from_RAM (ram_b),
        .o_Data (data_b), .o_Valid (valid_b), .i_Ready (ready_drv),
        .o_First (first_b), .o_Last (last_b)
    );

    initial begin
        ram_a = 8'h00;
        ram_b = 8'h00;
    end
    always @(posedge clk) begin
        if (rd_a) ram_a <= addr_a[7:0] + 8'h10;
        if (rd_b) ram_b <= addr_b[7:0] + 8'h10;
    end

    logic        busy_s, done_s, rd_s, valid_s, first_s, last_s;
    logic [14:0] addr_s;
    logic [7:0]  data_s;
    assign busy_s  = sel_b ? busy_b  : busy_a;
    assign done_s  = sel_b ? done_b  : done_a;
    assign rd_s    = sel_b ? rd_b    : rd_a;
    assign valid_s = sel_b ? valid_b : valid_a;
    assign first_s = sel_b ? first_b : first_a;
    assign last_s  = sel_b ? last_b  : last_a;
    assign addr_s  = sel_b ? addr_b  : addr_a;
    assign data_s  = sel_b ? data_b  : data_a;

    int n_checks = 0;
    int n_fail   = 0;

    int xd[$], xc[$], xf[$], xl[$], ra[$], rc[$];
    int done_cnt, done_cyc, busy1, busy_end, addr_end;
    int viol, hold_err, outstanding, v10, d10;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_idle(input string pfx);
        check({pfx, ".busy"},  int'(busy_s),  0);
        check({pfx, ".done"},  int'(done_s),  0);
        check({pfx, ".rd_en"}, int'(rd_s),    0);
        check({pfx, ".addr"},  int'(addr_s),  0);
        check({pfx, ".valid"}, int'(valid_s), 0);
        check({pfx, ".first"}, int'(first_s), 0);
        check({pfx, ".last"},  int'(last_s),  0);
        check({pfx, ".data"},  int'(data_s),  0);
    endtask

    // rdy_mode: 0 ready high, 1 ready on even cycles, 2 ready low until cycle 21.
    task automatic run_frame(input string pfx, input int sel_i, input int ncyc,
                             input int rdy_mode, input int rst_cyc, input int extra_start);
        bit prev_stall;
        int prev_data;
        int pop;
        xd.delete(); xc.delete(); xf.delete(); xl.delete(); ra.delete(); rc.delete();
        done_cnt = 0; done_cyc = -1; busy1 = -1; busy_end = -1; addr_end = -1;
        viol = 0; hold_err = 0; outstanding = 0; v10 = -1; d10 = -1;
        prev_stall = 1'b0; prev_data = 0;
        sel_b = sel_i[0];
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            start_drv = (c == 0) || (extra_start != 0 && (c == 1 || c == 3)) || (c == rst_cyc);
            rst_drv   = (c == rst_cyc);
            case (rdy_mode)
                1:       ready_drv = (c % 2 == 0);
                2:       ready_drv = (c >= 21);
                default: ready_drv = 1'b1;
            endcase
            #1;
            if (rst_cyc >= 0 && c == rst_cyc + 1) check_idle({pfx, ".after_rst"});
            pop = int'(valid_s && ready_drv);
            if (rd_s) begin
                ra.push_back(int'(addr_s));
                rc.push_back(c);
                if (outstanding - pop > 1) viol++;
            end
            if (prev_stall && (!valid_s || int'(data_s) != prev_data)) hold_err++;
            prev_stall = valid_s && !ready_drv;
            prev_data  = int'(data_s);
            if (pop != 0) begin
                xd.push_back(int'(data_s)); xc.push_back(c);
                xf.push_back(int'(first_s)); xl.push_back(int'(last_s));
                $display("%s xfer cyc=%0d data=%02h first=%0d last=%0d",
                         pfx, c, data_s, first_s, last_s);
            end
            outstanding += int'(rd_s) - pop;
            if (c == rst_cyc) outstanding = 0;
            if (done_s) begin
                done_cnt++;
                done_cyc = c;
            end
            if (c == 1) busy1 = int'(busy_s);
            if (c == 10) begin
                v10 = int'(valid_s);
                d10 = int'(data_s);
            end
            if (c == ncyc - 1) begin
                busy_end = int'(busy_s);
                addr_end = int'(addr_s);
            end
        end
        @(posedge clk);
        #1;
        start_drv = 1'b0;
        rst_drv   = 1'b0;
        ready_drv = 1'b1;
    endtask

    task automatic check_stream(input string pfx, input int n, input int first_cyc);
        check({pfx, ".count"}, xd.size(), n);
        for (int i = 0; i < n && i < xd.size(); i++) begin
            check($sformatf("%s.data%0d", pfx, i),  xd[i], 16 + i);
            check($sformatf("%s.first%0d", pfx, i), xf[i], (i == 0) ? 1 : 0);
            check($sformatf("%s.last%0d", pfx, i),  xl[i], (i == n - 1) ? 1 : 0);
            if (first_cyc >= 0) check($sformatf("%s.cyc%0d", pfx, i), xc[i], first_cyc + i);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation still running, required to finish");
        $fatal(1, "timeout");
    end

    initial begin
        int early;
        rst_drv = 1'b1; start_drv = 1'b0; ready_drv = 1'b1; sel_b = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_idle("reset_a");
        sel_b = 1'b1;
        #1;
        check_idle("reset_b");
        sel_b = 1'b0;
        rst_drv = 1'b0;

        // Continuous ready: bytes on cycles 2..9, done on cycle 10.
        run_frame("stream", 0, 13, 0, -1, 0);
        check_stream("stream", 8, 2);
        check("stream.rd_first_cyc",  (rc.size() > 0) ? rc[0] : -1, 1);
        check("stream.rd_first_addr", (ra.size() > 0) ? ra[0] : -1, 0);
        check("stream.busy1",    busy1, 1);
        check("stream.done_cyc", done_cyc, 10);
        check("stream.done_cnt", done_cnt, 1);
        check("stream.busy_end", busy_end, 0);
        check("stream.addr_hold", addr_end, 7);

        // Alternating ready plus start pulses while busy.
        run_frame("toggle", 0, 26, 1, -1, 1);
        check_stream("toggle", 8, -1);
        check("toggle.over_issue", viol, 0);
        check("toggle.hold", hold_err, 0);
        check("toggle.done_cnt", done_cnt, 1);

        // Consumer stalled for the first 21 cycles.
        run_frame("stall", 0, 32, 2, -1, 0);
        early = 0;
        foreach (rc[i]) if (rc[i] < 21) early++;
        check("stall.reads_early", early, 2);
        check("stall.rd_addr0", (ra.size() > 0) ? ra[0] : -1, 0);
        check("stall.rd_addr1", (ra.size() > 1) ? ra[1] : -1, 1);
        check("stall.valid10", v10, 1);
        check("stall.data10",  d10, 16);
        check("stall.hold", hold_err, 0);
        check("stall.over_issue", viol, 0);
        check_stream("stall", 8, 21);
        check("stall.done_cyc", done_cyc, 29);

        // Reset (with a coincident start) mid-frame, then a fresh frame.
        run_frame("midrst", 0, 7, 0, 5, 0);
        run_frame("restart", 0, 13, 0, -1, 0);
        check_stream("restart", 8, 2);
        check("restart.done_cyc", done_cyc, 10);

        // One-byte frame with start pulses while busy.
        run_frame("single", 1, 8, 0, -1, 1);
        check_stream("single", 1, 2);
        check("single.done_cyc", done_cyc, 3);
        check("single.done_cnt", done_cnt, 1);
        check("single.reads", ra.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
